mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive granted cycles while the other requester waits and the owner is unlocked.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_addr, i_data_in  input  16 each  instruction-cache FSM address / write data.
REQ-005 i_rd, i_wr, i_lock  input  1 each  instruction-cache read, write, burst-lock (held across a multi-word line fill/evict).
REQ-006 d_addr, d_data_in, d_rd, d_wr, d_lock  input  16/16/1/1/1  data-cache equivalents of REQ-004/005.
REQ-007 m_data_out  input  16  memory read data; m_busy  input  4  bank busy; m_stall, m_err  input  1 each.
REQ-008 fm_addr, fm_data_in  output  16 each; fm_rd, fm_wr  output  1 each  four-bank memory request port.
REQ-009 i_gnt, d_gnt  output  1 each  current grant (one-hot or both 0).
REQ-010 i_stall, d_stall  output  1 each; i_err, d_err  output  1 each; data_out  output  16  read data to both requesters.

Function
REQ-011 State register SHALL hold IDLE, GNT_I, GNT_D; plus last flop (0=I,1=D) and hold counter of width clog2(MAX_HOLD).
REQ-012 x_req = x_rd | x_wr | x_lock for x in {i,d}.
REQ-013 IDLE: only one req -> grant it next edge; both -> grant the one not equal to last; none -> stay.
REQ-014 Arbitration latency SHALL be exactly 1 cycle: request seen in IDLE, memory port driven from the following cycle.
REQ-015 In GNT_x, fm_addr/fm_data_in/fm_rd/fm_wr SHALL equal x's inputs combinationally; in IDLE all four SHALL be 0.
REQ-016 i_gnt = (state==GNT_I), d_gnt = (state==GNT_D); last updates to x on every entry to GNT_x.
REQ-017 GNT_x with x_req=0: other requesting -> GNT_other next edge (no bubble); else -> IDLE.
REQ-018 Hold counter SHALL clear on any grant change and in IDLE; in GNT_x it increments while other requests, saturating at MAX_HOLD-1.
REQ-019 GNT_x with counter==MAX_HOLD-1, x_lock=0, other requesting -> GNT_other next edge, even if x_req=1.
REQ-020 x_lock=1 SHALL block all preemption; counter saturates, no switch.
REQ-021 No grant change on an edge where m_stall=1 and the owner drives fm_rd|fm_wr; state and counter hold (counter still saturating-increments).
REQ-022 x_stall = x_req & (~x_gnt | m_stall).
REQ-023 data_out = m_data_out at all times; x_err = m_err & x_gnt.
REQ-024 m_busy SHALL not affect arbitration; it is ignored except for pass-through to nothing (owners consult memory directly).
REQ-025 Both rd and wr from one requester in one cycle: both forwarded unchanged; memory error reported via x_err.

Reset
REQ-026 On rst edge: state=IDLE, last=0 (first tie goes to D), counter=0.
REQ-027 While rst=1, fm_rd, fm_wr SHALL be forced 0 combinationally, i_gnt=d_gnt=0, stalls=0, even mid-burst.
REQ-028 After rst deasserts, locks held from before reset SHALL be treated as fresh requests via REQ-013.

Verification
REQ-029 Tie after reset: i_rd=d_rd=1 at cycle 1 -> d_gnt=1 cycle 2, fm_addr=d_addr, i_stall=1; d_rd drops -> i_gnt=1 next cycle, no IDLE bubble.
REQ-030 Starvation: MAX_HOLD=4, d_rd held, d_lock=0, i_rd asserted -> grant moves to I after exactly 4 overlapping GNT_D cycles.
REQ-031 Lock: d_lock=1 for 20 cycles with i_rd=1 -> d_gnt stays 1 all 20 cycles; i_gnt=1 the cycle after d_lock and d_req drop.
REQ-032 Stall hold: in GNT_I with i_wr=1, m_stall=1, hold counter saturated, d_wr=1 -> no switch until m_stall=0; i_stall=1 throughout.
REQ-033 Error routing: GNT_D, m_err=1 -> d_err=1, i_err=0; IDLE with m_err=1 -> both 0.
REQ-034 Reset mid-burst: rst during GNT_I with i_lock=1 -> fm_rd=fm_wr=0 that cycle, state IDLE next cycle, grant re-established one cycle after rst drops.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: shares one four-bank memory port between the
// instruction-cache and data-cache FSMs with alternating ties, hold limit and burst lock.
module mem_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_lock,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic        d_lock,
  input  logic [15:0] m_data_out,
  input  logic [3:0]  m_busy,
  input  logic        m_stall,
  input  logic        m_err,
  output logic [15:0] fm_addr,
  output logic [15:0] fm_data_in,
  output logic        fm_rd,
  output logic        fm_wr,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        i_stall,
  output logic        d_stall,
  output logic        i_err,
  output logic        d_err,
  output logic [15:0] data_out
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  logic [1:0]    state, state_nxt, other_state;
  logic          last, last_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic          i_req, d_req;
  logic          own_req, oth_req, own_lock, own_xfer;
  logic          unused_busy;

  assign i_req       = i_rd | i_wr | i_lock;
  assign d_req       = d_rd | d_wr | d_lock;
  assign unused_busy = ^m_busy;
  assign hold_inc    = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + CW'(1);

  always_comb begin
    own_req     = 1'b0;
    oth_req     = 1'b0;
    own_lock    = 1'b0;
    own_xfer    = 1'b0;
    other_state = IDLE;
    case (state)
      GNT_I: begin
        own_req     = i_req;
        oth_req     = d_req;
        own_lock    = i_lock;
        own_xfer    = i_rd | i_wr;
        other_state = GNT_D;
      end
      GNT_D: begin
        own_req     = d_req;
        oth_req     = i_req;
        own_lock    = d_lock;
        own_xfer    = d_rd | d_wr;
        other_state = GNT_I;
      end
      default: ;
    endcase
  end

  // Priority: a stalled owner transfer freezes the grant, then release, then hold-limit preemption.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    if (state == IDLE) begin
      hold_nxt = '0;
      if (i_req && d_req)
        state_nxt = last ? GNT_I : GNT_D;
      else if (i_req)
        state_nxt = GNT_I;
      else if (d_req)
        state_nxt = GNT_D;
    end else if (m_stall && own_xfer) begin
      if (oth_req)
        hold_nxt = hold_inc;
    end else if (!own_req) begin
      state_nxt = oth_req ? other_state : IDLE;
      hold_nxt  = '0;
    end else if (oth_req && !own_lock && hold_cnt == HOLD_MAX) begin
      state_nxt = other_state;
      hold_nxt  = '0;
    end else if (oth_req) begin
      hold_nxt = hold_inc;
    end
  end

  always_comb begin
    last_nxt = last;
    if (state_nxt == GNT_I && state != GNT_I)
      last_nxt = 1'b0;
    else if (state_nxt == GNT_D && state != GNT_D)
      last_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Reset masks strobes and grants immediately, even while a locked burst is in flight.
  always_comb begin
    fm_addr    = '0;
    fm_data_in = '0;
    fm_rd      = 1'b0;
    fm_wr      = 1'b0;
    case (state)
      GNT_I: begin
        fm_addr    = i_addr;
        fm_data_in = i_data_in;
        fm_rd      = i_rd;
        fm_wr      = i_wr;
      end
      GNT_D: begin
        fm_addr    = d_addr;
        fm_data_in = d_data_in;
        fm_rd      = d_rd;
        fm_wr      = d_wr;
      end
      default: ;
    endcase
    if (rst) begin
      fm_rd = 1'b0;
      fm_wr = 1'b0;
    end
  end

  assign i_gnt    = (state == GNT_I) && !rst;
  assign d_gnt    = (state == GNT_D) && !rst;
  assign i_stall  = !rst && i_req && (!i_gnt || m_stall);
  assign d_stall  = !rst && d_req && (!d_gnt || m_stall);
  assign i_err    = m_err & i_gnt;
  assign d_err    = m_err & d_gnt;
  assign data_out = m_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner-case sequences,
// then randomized traffic against an ownership-level reference model.
module tb_mem_arbiter;

  localparam int MAX_HOLD = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_addr, i_data_in, d_addr, d_data_in, m_data_out;
  logic        i_rd, i_wr, i_lock, d_rd, d_wr, d_lock, m_stall, m_err;
  logic [3:0]  m_busy;
  logic [15:0] fm_addr, fm_data_in, data_out;
  logic        fm_rd, fm_wr, i_gnt, d_gnt, i_stall, d_stall, i_err, d_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: who owns the port, who was granted last, how long the other has waited.
  int model_owner  = OWN_NONE;
  bit model_last_d = 1'b0;
  int model_wait   = 0;

  typedef struct {
    logic rst, i_rd, i_wr, i_lock, d_rd, d_wr, d_lock, m_stall, m_err;
    logic i_gnt, d_gnt, i_stall, d_stall, i_err, d_err;
  } vec_t;

  vec_t vecs[10];

  mem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_data_in(i_data_in), .i_rd(i_rd), .i_wr(i_wr), .i_lock(i_lock),
    .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr), .d_lock(d_lock),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_stall(m_stall), .m_err(m_err),
    .fm_addr(fm_addr), .fm_data_in(fm_data_in), .fm_rd(fm_rd), .fm_wr(fm_wr),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .i_stall(i_stall), .d_stall(d_stall),
    .i_err(i_err), .d_err(d_err), .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_grant(input int who);
    model_owner  = who;
    model_last_d = (who == OWN_D);
    model_wait   = 0;
  endtask

  task automatic model_step();
    bit req_i, req_d, own_req, oth_req, own_lock, own_xfer;
    int other;
    req_i = i_rd | i_wr | i_lock;
    req_d = d_rd | d_wr | d_lock;
    if (rst) begin
      model_owner  = OWN_NONE;
      model_last_d = 1'b0;
      model_wait   = 0;
      return;
    end
    if (model_owner == OWN_NONE) begin
      if (req_i && req_d)
        model_grant(model_last_d ? OWN_I : OWN_D);
      else if (req_i)
        model_grant(OWN_I);
      else if (req_d)
        model_grant(OWN_D);
      return;
    end
    own_req  = (model_owner == OWN_I) ? req_i : req_d;
    oth_req  = (model_owner == OWN_I) ? req_d : req_i;
    own_lock = (model_owner == OWN_I) ? i_lock : d_lock;
    own_xfer = (model_owner == OWN_I) ? (i_rd | i_wr) : (d_rd | d_wr);
    other    = (model_owner == OWN_I) ? OWN_D : OWN_I;
    if (m_stall && own_xfer) begin
      if (oth_req && model_wait < MAX_HOLD - 1) model_wait++;
    end else if (!own_req) begin
      if (oth_req) model_grant(other);
      else begin
        model_owner = OWN_NONE;
        model_wait  = 0;
      end
    end else if (oth_req && !own_lock && model_wait + 1 >= MAX_HOLD) begin
      model_grant(other);
    end else if (oth_req && model_wait < MAX_HOLD - 1) begin
      model_wait++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_rd = 0; i_wr = 0; i_lock = 0; d_rd = 0; d_wr = 0; d_lock = 0;
    m_stall = 0; m_err = 0; m_busy = 4'h0;
    i_addr = 16'h1111; i_data_in = 16'hA1A1; d_addr = 16'h2222; d_data_in = 16'hD2D2;
    m_data_out = 16'h5A5A;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst = v.rst; i_rd = v.i_rd; i_wr = v.i_wr; i_lock = v.i_lock;
    d_rd = v.d_rd; d_wr = v.d_wr; d_lock = v.d_lock; m_stall = v.m_stall; m_err = v.m_err;
  endtask

  initial begin
    int n;
    logic [15:0] exp_addr;
    logic        exp_rd, exp_wr, exp_ig, exp_dg;

    // rst i_rd i_wr i_lk d_rd d_wr d_lk stall err | ig dg is ds ie de
    vecs[0] = '{H, H, L, L, H, L, L, L, H,  L, L, L, L, L, L};
    vecs[1] = '{L, H, L, L, H, L, L, L, H,  L, L, H, H, L, L};
    vecs[2] = '{L, H, L, L, H, L, L, L, H,  L, H, H, L, L, H};
    vecs[3] = '{L, H, L, L, L, L, L, L, L,  L, H, H, L, L, L};
    vecs[4] = '{L, H, L, L, L, L, L, L, H,  H, L, L, L, H, L};
    vecs[5] = '{L, L, L, L, L, L, L, L, L,  H, L, L, L, L, L};
    vecs[6] = '{L, L, L, L, L, L, L, L, L,  L, L, L, L, L, L};
    vecs[7] = '{L, H, L, L, H, L, L, L, L,  L, L, H, H, L, L};
    vecs[8] = '{L, H, L, L, H, L, L, H, L,  L, H, H, H, L, L};
    vecs[9] = '{L, H, L, L, H, L, L, L, L,  L, H, H, L, L, L};

    rst = 1;
    clear_inputs();
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_gnt", i), 32'({i_gnt, d_gnt}), 32'({vecs[i].i_gnt, vecs[i].d_gnt}));
      check_output($sformatf("vec%0d_stall", i), 32'({i_stall, d_stall}), 32'({vecs[i].i_stall, vecs[i].d_stall}));
      check_output($sformatf("vec%0d_err", i), 32'({i_err, d_err}), 32'({vecs[i].i_err, vecs[i].d_err}));
      exp_addr = vecs[i].i_gnt ? i_addr : (vecs[i].d_gnt ? d_addr : 16'h0);
      exp_rd   = vecs[i].i_gnt ? i_rd : (vecs[i].d_gnt ? d_rd : 1'b0);
      check_output($sformatf("vec%0d_addr", i), 32'(fm_addr), 32'(exp_addr));
      check_output($sformatf("vec%0d_rd", i), 32'(fm_rd), 32'(exp_rd));
      check_output($sformatf("vec%0d_data", i), 32'(data_out), 32'h5A5A);
      tick();
    end

    // Hold limit: D keeps requesting while I waits; I takes over after exactly MAX_HOLD cycles.
    do_reset();
    d_rd = 1;
    tick();
    i_rd = 1;
    #1;
    n = 0;
    while (d_gnt === 1'b1 && n < 20) begin
      n++;
      tick();
      #1;
    end
    check_output("starve_cycles", 32'(n), 32'(MAX_HOLD));
    check_output("starve_i_gnt", 32'(i_gnt), 32'd1);

    // A locked D burst is never preempted; release hands over with no idle gap.
    do_reset();
    d_lock = 1;
    i_rd = 1;
    tick();
    #1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (d_gnt === 1'b1 && i_stall === 1'b1) n++;
      tick();
      #1;
    end
    check_output("lock_held", 32'(n), 32'd20);
    d_lock = 0;
    #1;
    check_output("lock_release_d", 32'(d_gnt), 32'd1);
    tick();
    #1;
    check_output("lock_handover_i", 32'(i_gnt), 32'd1);

    // A stalled owner write keeps the grant past the hold limit until the stall clears.
    do_reset();
    i_wr = 1;
    tick();
    d_wr = 1;
    m_stall = 1;
    #1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (i_gnt === 1'b1 && i_stall === 1'b1 && fm_wr === 1'b1) n++;
      tick();
      #1;
    end
    check_output("stall_hold", 32'(n), 32'd6);
    m_stall = 0;
    #1;
    check_output("stall_release_i", 32'({i_gnt, i_stall}), 32'b10);
    tick();
    #1;
    check_output("stall_switch_d", 32'({i_gnt, d_gnt}), 32'b01);

    // Reset in the middle of a locked I burst with read and write both active.
    do_reset();
    i_lock = 1;
    i_rd = 1;
    i_wr = 1;
    tick();
    #1;
    check_output("burst_strobes", 32'({i_gnt, fm_rd, fm_wr}), 32'b111);
    rst = 1;
    #1;
    check_output("rst_strobes", 32'({fm_rd, fm_wr}), 32'b00);
    check_output("rst_gnt_stall", 32'({i_gnt, d_gnt, i_stall, d_stall}), 32'b0000);
    tick();
    rst = 0;
    #1;
    check_output("post_rst_idle", 32'({i_gnt, i_stall}), 32'b01);
    tick();
    #1;
    check_output("post_rst_regrant", 32'(i_gnt), 32'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      i_rd       = $urandom_range(0, 2) == 0;
      i_wr       = $urandom_range(0, 3) == 0;
      i_lock     = $urandom_range(0, 9) == 0;
      d_rd       = $urandom_range(0, 2) == 0;
      d_wr       = $urandom_range(0, 3) == 0;
      d_lock     = $urandom_range(0, 9) == 0;
      m_stall    = $urandom_range(0, 3) == 0;
      m_err      = $urandom_range(0, 5) == 0;
      m_busy     = 4'($urandom);
      i_addr     = 16'($urandom);
      i_data_in  = 16'($urandom);
      d_addr     = 16'($urandom);
      d_data_in  = 16'($urandom);
      m_data_out = 16'($urandom);
      #1;
      exp_ig   = !rst && model_owner == OWN_I;
      exp_dg   = !rst && model_owner == OWN_D;
      exp_addr = (model_owner == OWN_I) ? i_addr : ((model_owner == OWN_D) ? d_addr : 16'h0);
      exp_rd   = !rst && ((model_owner == OWN_I) ? i_rd : ((model_owner == OWN_D) ? d_rd : 1'b0));
      exp_wr   = !rst && ((model_owner == OWN_I) ? i_wr : ((model_owner == OWN_D) ? d_wr : 1'b0));
      check_output($sformatf("rnd%0d_ctl", c),
                   32'({i_gnt, d_gnt, fm_rd, fm_wr, i_stall, d_stall, i_err, d_err}),
                   32'({exp_ig, exp_dg, exp_rd, exp_wr,
                        !rst && (i_rd | i_wr | i_lock) && (!exp_ig || m_stall),
                        !rst && (d_rd | d_wr | d_lock) && (!exp_dg || m_stall),
                        m_err && exp_ig, m_err && exp_dg}));
      check_output($sformatf("rnd%0d_addr", c), 32'(fm_addr), 32'(exp_addr));
      check_output($sformatf("rnd%0d_wdata", c), 32'(fm_data_in),
                   32'((model_owner == OWN_I) ? i_data_in : ((model_owner == OWN_D) ? d_data_in : 16'h0)));
      check_output($sformatf("rnd%0d_rdata", c), 32'(data_out), 32'(m_data_out));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
